seven_seg_scan_mux: RTL and testbench
=====================================

Name: seven_seg_scan_mux

Overview:
- Upstream driver for the hex-to-segment decoder on the 4-digit common-anode display.
- Holds a 16-bit value plus per-digit decimal-point and blank masks, and time-multiplexes the four digits.
- Each slot presents one nibble to the decoder, drives one active-low anode and drives the matching decimal point.
- New values are double-buffered and take effect only at a frame boundary, so the display never tears.

Parameters:
- PRESCALE, 50000, clk cycles per digit slot (1..2^20); the 50000 default gives 1 kHz digit rate at 50 MHz.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- load, input, 1, single-cycle strobe; captures value, dp_in, blank_in and lz_en.
- value, input, 16, four hex nibbles; [3:0] is digit 0 (rightmost).
- dp_in, input, 4, per-digit decimal point enable, 1 = lit.
- blank_in, input, 4, per-digit forced blank, 1 = dark.
- lz_en, input, 1, leading-zero suppression enable.
- digit, output, 4, nibble for the downstream decoder.
- an, output, 4, anode enables, active low.
- dp, output, 1, decimal point, active low.
- frame_done, output, 1, one-cycle pulse when the slot index wraps 3->0.

Behaviour:
- Reset (async assert, sync release) values:
  - prescale count = 0, idx = 0.
  - display regs and pending regs = 0, pending_valid = 0.
  - an = 4'b1110, digit = 0, dp = 1, frame_done = 0.
- Prescaler:
  - Counts 0..PRESCALE-1; tick asserts for one cycle when count == PRESCALE-1, then count wraps to 0.
  - With PRESCALE = 1, tick is asserted every cycle.
- On tick, idx <= (idx+1) mod 4.
- an, digit and dp are registers loaded on the same edge as idx, with values computed for the new idx. No combinational path to outputs.
- Load capture:
  - load high: pending <= {value, dp_in, blank_in, lz_en} and pending_valid <= 1.
  - A later load before commit overwrites pending; last load wins.
- Commit:
  - On a tick where idx == 3 (the wrap), display <= pending if pending_valid, then pending_valid <= 0.
  - The slot-0 outputs on that same edge use the committed data.
- Simultaneous load and wrap tick: the load data is committed directly to display on that edge, and pending_valid <= 0.
- frame_done = 1 on the cycle after the wrap edge, for exactly one cycle.
- Per-slot output for digit i:
  - an: bit i = 0, all other bits = 1.
  - If the slot is blanked: an = 4'b1111 and dp = 1.
  - digit = display nibble i, even when blanked.
  - dp = ~dp_disp[i].
- Blank conditions:
  - blank_disp[i] = 1, or
  - lz_disp = 1 and i >= 1 and display nibbles i..3 are all zero.
  - Digit 0 is never leading-zero suppressed.
- Reset mid-scan: all state returns immediately to reset values, including any pending load.

Decomposition:
- Package seg_pkg holds:
  - Digit index type (2 bits) and NUM_DIGITS = 4.
  - ANODE_OFF = 4'b1111.
  - PRESCALE_W = 20.
  - Function digit_blank(nibbles, idx, lz, blank).
- Sub-module seg_refresh_tick:
  - Parameterised prescaler, PRESCALE in, tick out.
  - Reused by any other refresh-scanned display.

Test Plan:
1. Reset, then release with PRESCALE = 4 and no load -> an = 1110, digit = 0, dp = 1; idx advances every 4 cycles; an cycles 1101, 1011, 0111, 1110; frame_done pulses once per 16 cycles.
2. load value = 16'h1234, dp_in = 4'b0100, then wait for the wrap -> per slot, digit = 4, 3, 2, 1 on an = 1110, 1101, 1011, 0111; dp = 0 only in the slot where an = 1011.
3. load 16'hABCD while idx = 1 -> slots 2 and 3 still show the old data; the new data appears from the next slot 0; frame_done coincides with the first 'D'.
4. load 16'h0050 with lz_en = 1 -> slots 3 and 2 have an = 1111; slot 1 shows 5; slot 0 shows 0. Same with 16'h0000 -> only slot 0 is lit, showing 0.
5. load asserted exactly on the wrap tick with 16'h00FF -> the slot-0 output on that edge is F and the new data takes effect without waiting a frame. load 16'h1111 then 16'h2222 before the wrap -> only 2s are displayed.
6. Assert rst during slot 2 with a pending load -> outputs are immediately at reset values; after release the display shows 0000 and the pending data is discarded.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and helpers for refresh-scanned
// seven-segment display drivers.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int PRESCALE_W = 20;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } disp_t;

  // Digit is dark when forced blank, or when it is
  // a leading zero (digit 0 always stays lit).
  function automatic logic digit_blank(
    input logic [15:0] nib,
    input idx_t        idx,
    input logic        lz,
    input logic [3:0]  blank
  );
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && nib[i*4 +: 4] != 4'd0)
        nz = 1'b1;
    end
    return blank[idx] | (lz & (idx != 2'd0) & ~nz);
  endfunction

endpackage

// File: rtl/seg_refresh_tick.sv
// Free-running prescaler producing a one-cycle
// tick every PRESCALE clocks.
import seg_pkg::*;

module seg_refresh_tick #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST =
    PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..PRESCALE-1 and wrap on the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + PRESCALE_W'(1);
  end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Four-digit common-anode scan multiplexer with
// frame-synchronous double-buffered updates.
import seg_pkg::*;

module seven_seg_scan_mux #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        lz_en,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  logic  tick;
  logic  wrap;
  logic  pv;
  logic  blk;
  idx_t  idx;
  idx_t  idx_nxt;
  disp_t disp;
  disp_t disp_nxt;
  disp_t pend;
  disp_t ld;
  logic [3:0] an_nxt;
  logic [3:0] digit_nxt;
  logic       dp_nxt;

  seg_refresh_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign ld.val   = value;
  assign ld.dp    = dp_in;
  assign ld.blank = blank_in;
  assign ld.lz    = lz_en;

  assign wrap = tick & (idx == 2'd3);

  // Next slot and its outputs; a load on the wrap
  // edge bypasses the pending buffer.
  always_comb begin
    idx_nxt  = idx + 2'd1;
    disp_nxt = disp;
    if (wrap) begin
      if (load)
        disp_nxt = ld;
      else if (pv)
        disp_nxt = pend;
    end
    blk = digit_blank(disp_nxt.val, idx_nxt,
                      disp_nxt.lz, disp_nxt.blank);
    digit_nxt = disp_nxt.val[{idx_nxt, 2'b00} +: 4];
    an_nxt    = ~(4'b0001 << idx_nxt);
    dp_nxt    = ~disp_nxt.dp[idx_nxt];
    if (blk) begin
      an_nxt = ANODE_OFF;
      dp_nxt = 1'b1;
    end
  end

  // Pending buffer: last load wins until the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      pv   <= 1'b0;
    end else if (load && !wrap) begin
      pend <= ld;
      pv   <= 1'b1;
    end else if (wrap) begin
      pv   <= 1'b0;
    end
  end

  // Slot index, live display data and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      disp       <= '0;
      an         <= 4'b1110;
      digit      <= 4'd0;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        idx   <= idx_nxt;
        disp  <= disp_nxt;
        an    <= an_nxt;
        digit <= digit_nxt;
        dp    <= dp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Randomised self-checking bench for the scan
// multiplexer against a frame-level model.
module tb_seven_seg_scan_mux;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  seven_seg_scan_mux #(.PRESCALE(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .lz_en     (lz_en),
    .digit     (digit),
    .an        (an),
    .dp        (dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model: edges since reset, shown and queued data
  int          k;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp, m_blk, p_blk;
  logic        m_lz, p_lz, p_v;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, obs, exp, $time);
  endtask

  function automatic int cur_idx();
    return (k / P) % 4;
  endfunction

  task automatic model_reset();
    k = 0;
    m_val = '0; m_dp = '0; m_blk = '0; m_lz = 1'b0;
    p_val = '0; p_dp = '0; p_blk = '0; p_lz = 1'b0;
    p_v = 1'b0;
  endtask

  task automatic check_outputs();
    int   i;
    logic bl;
    logic [3:0] e_an;
    logic [3:0] e_dig;
    logic e_dp;
    i = cur_idx();
    bl = m_blk[i] ||
         (m_lz && i >= 1 && (m_val >> (4 * i)) == 0);
    e_dig = 4'((m_val >> (4 * i)) & 16'hF);
    e_an = bl ? 4'hF : 4'(4'hF ^ (1 << i));
    e_dp = bl ? 1'b1 : !m_dp[i];
    chk("an", 32'(an), 32'(e_an));
    chk("digit", 32'(digit), 32'(e_dig));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done),
        32'(k > 0 && k % (4 * P) == 0));
  endtask

  // One clock: drive at negedge, model the edge,
  // check at the following negedge.
  task automatic step(input logic ld,
                      input logic [15:0] v,
                      input logic [3:0] d,
                      input logic [3:0] b,
                      input logic lz);
    load = ld; value = v; dp_in = d;
    blank_in = b; lz_en = lz;
    @(posedge clk);
    k++;
    if (ld) begin
      p_val = v; p_dp = d; p_blk = b; p_lz = lz;
      p_v = 1'b1;
    end
    if (k % (4 * P) == 0) begin
      if (p_v) begin
        m_val = p_val; m_dp = p_dp;
        m_blk = p_blk; m_lz = p_lz;
      end
      p_v = 1'b0;
    end
    @(negedge clk);
    load = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic to_slot(input int s);
    for (int t = 0; t < 8 * P && cur_idx() != s; t++)
      idle(1);
  endtask

  task automatic before_wrap();
    for (int t = 0; t < 8 * P && (k + 1) % (4 * P) != 0; t++)
      idle(1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'h e);
    chk("rst_digit", 32'(digit), 32'h0);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    check_outputs();

    idle(36);

    step(1'b1, 16'h1234, 4'b0100, 4'h0, 1'b0);
    idle(40);

    to_slot(1);
    step(1'b1, 16'hABCD, 4'b0001, 4'h0, 1'b0);
    idle(40);

    step(1'b1, 16'h0050, 4'h0, 4'h0, 1'b1);
    idle(36);
    step(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
    idle(36);

    before_wrap();
    step(1'b1, 16'h00FF, 4'h0, 4'h0, 1'b0);
    idle(20);
    step(1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
    idle(2);
    step(1'b1, 16'h2222, 4'h0, 4'h0, 1'b0);
    idle(36);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0)
        step(1'b1, 16'($urandom), 4'($urandom),
             4'($urandom_range(3) == 0 ? $urandom : 0),
             1'($urandom));
      else
        idle(1);
    end

    step(1'b1, 16'h9876, 4'hF, 4'h0, 1'b0);
    idle(36);
    to_slot(2);
    step(1'b1, 16'h4321, 4'h3, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'h e);
    chk("arst_digit", 32'(digit), 32'h0);
    chk("arst_dp", 32'(dp), 32'h1);
    chk("arst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs();
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
